// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared defaults and width helpers for the switch debouncer.
// Optional pulse outputs are enabled by SW_DEBOUNCE_PULSE_EN.
package sw_debounce_pkg;

  localparam int SW_WIDTH        = 18;
  localparam int SW_CLK_DIV      = 50000;
  localparam int SW_STABLE_TICKS = 10;

  // Stable-tick counter width: must hold 0..STABLE_TICKS.
  function automatic int cnt_width(input int stable);
    return (stable < 1) ? 1 : $clog2(stable + 1);
  endfunction

  // Prescaler width: must hold 0..CLK_DIV-1.
  function automatic int div_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: raw switch lines in, debounced levels and strobes out.
// Pulse signals exist only when SW_DEBOUNCE_PULSE_EN is defined.
interface sw_debounce_if
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic             tick;
`ifdef SW_DEBOUNCE_PULSE_EN
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
`endif

  modport master (
    output sw_raw,
    input  sw_out,
`ifdef SW_DEBOUNCE_PULSE_EN
    input  rise_pulse,
    input  fall_pulse,
`endif
    input  tick
  );

  modport slave (
    input  sw_raw,
    output sw_out,
`ifdef SW_DEBOUNCE_PULSE_EN
    output rise_pulse,
    output fall_pulse,
`endif
    output tick
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: one line's synchronizer, stable-tick counter and output flop.
// Edge pulses are built only when SW_DEBOUNCE_PULSE_EN is defined.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int   STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic raw_i,
`ifdef SW_DEBOUNCE_PULSE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic out_o
);

  localparam int            CW   = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          out_q;
  logic          out_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          diff;
  logic          fire;

  assign diff = sync2_q ^ out_q;
  assign fire = diff & tick_i & (cnt_q == LAST);

  // Two-flop synchronizer; only the second stage is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync2_q == sync1_q ? sync2_q : sync1_q;
    end
  end

  // Counter clears on agreement, advances on ticks, and stops at LAST.
  always_comb begin
    cnt_d = cnt_q;
    out_d = out_q;
    if (!diff) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        out_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter and accepted level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      out_q <= RESET_VAL;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

`ifdef SW_DEBOUNCE_PULSE_EN
  logic rise_q;
  logic fall_q;

  // Pulses line up with the cycle the new level first appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= fire & sync2_q;
      fall_q <= fire & ~sync2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: shared sample prescaler plus one debouncer per switch line.
// Define SW_DEBOUNCE_PULSE_EN to add per-line rise/fall pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int               WIDTH        = SW_WIDTH,
  parameter int               CLK_DIV      = SW_CLK_DIV,
  parameter int               STABLE_TICKS = SW_STABLE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input logic         clk,
  input logic         reset_n,
  sw_debounce_if.slave bus
);

  localparam int            DW   = div_width(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  logic [DW-1:0]    div_q;
  logic [DW-1:0]    div_d;
  logic             tick;
  logic [WIDTH-1:0] out_w;

  assign tick  = (div_q == DMAX);
  assign div_d = tick ? '0 : div_q + DW'(1);

  // Free-running prescaler; tick marks its last count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign bus.tick   = tick;
  assign bus.sw_out = out_w;

`ifdef SW_DEBOUNCE_PULSE_EN
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  assign bus.rise_pulse = rise_w;
  assign bus.fall_pulse = fall_w;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VAL   (RESET_VAL[i])
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .tick_i (tick),
      .raw_i  (bus.sw_raw[i]),
`ifdef SW_DEBOUNCE_PULSE_EN
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i]),
`endif
      .out_o  (out_w[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: table vectors, corner sequences and a random run
// checked against a tick-counting reference model.
module tb_sw_debounce;

  localparam int W  = 18;
  localparam int D  = 4;
  localparam int ST = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  sw_debounce_if #(.WIDTH(W)) bus ();

  sw_debounce #(
    .WIDTH       (W),
    .CLK_DIV     (D),
    .STABLE_TICKS(ST),
    .RESET_VAL   ('0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int v,
                             input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // Reference model: a line flips at the tick that makes ST ticks
  // seen since the synchronized input started disagreeing.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  int           m_edges;
  int           m_start [W];
  logic         m_tick;

  assign m_tick = (m_edges % D) == D - 1;

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / D - a / D;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1    <= '0;
      m_s2    <= '0;
      m_out   <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_edges <= 0;
      for (int i = 0; i < W; i++) m_start[i] <= -1;
    end else begin
      m_s1    <= bus.sw_raw;
      m_s2    <= m_s1;
      m_edges <= m_edges + 1;
      m_rise  <= '0;
      m_fall  <= '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_out[i]) begin
          m_start[i] <= -1;
        end else if (m_tick &&
                     ticks_in(m_start[i] < 0 ? m_edges : m_start[i],
                              m_edges) >= ST) begin
          m_out[i]   <= m_s2[i];
          m_start[i] <= -1;
          m_rise[i]  <= m_s2[i];
          m_fall[i]  <= ~m_s2[i];
        end else if (m_start[i] < 0) begin
          m_start[i] <= m_edges;
        end
      end
    end
  end

  logic [2*W-1:0] dut_p;
  logic [2*W-1:0] mod_p;
`ifdef SW_DEBOUNCE_PULSE_EN
  assign dut_p = {bus.rise_pulse, bus.fall_pulse};
  assign mod_p = {m_rise, m_fall};
`else
  assign dut_p = '0;
  assign mod_p = '0;
`endif

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en)
      check("model", {bus.sw_out, bus.tick, dut_p},
            {m_out, m_tick, mod_p});
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges elapsed until sw_out[b] shows val; 0 on timeout.
  task automatic wait_bit(input int b, input logic val, output int n);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.sw_out[b] === val) begin
        n = c - 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    int chg;
    int split;

    vecs[0] = '{18'h00000, 20, 18'h00000};
    vecs[1] = '{18'h2AAAA, 20, 18'h2AAAA};
    vecs[2] = '{18'h15555,  5, 18'h2AAAA};
    vecs[3] = '{18'h15555, 20, 18'h15555};
    vecs[4] = '{18'h00F0F, 20, 18'h00F0F};
    vecs[5] = '{18'h3FFFF,  8, 18'h00F0F};
    vecs[6] = '{18'h00F0F, 20, 18'h00F0F};

    bus.sw_raw = '0;
    chk_en     = 1'b1;
    #12;
    check("reset_out", bus.sw_out, '0);
    check("reset_tick", bus.tick, 1'b0);

    // Tick phase after release
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", k + 1), bus.tick, (k % D) == D - 1);
    end
    check("idle_out", bus.sw_out, '0);
    step(1);

    // Single rise on bit 0
    bus.sw_raw[0] = 1'b1;
    wait_bit(0, 1'b1, n);
    check_range("rise0_lat", n, 11, 14);
`ifdef SW_DEBOUNCE_PULSE_EN
    check("rise0_pulse", bus.rise_pulse[0], 1'b1);
`endif
    step(1);

    // Short glitch on bit 5
    bus.sw_raw[5] = 1'b1;
    step(3);
    bus.sw_raw[5] = 1'b0;
    step(10);
    check("glitch5_out", bus.sw_out[5], 1'b0);
    check("glitch5_cnt", dut.g_bit[5].u_bit.cnt_q, '0);

    // Bounce on bit 17, then a final hold at 0
    bus.sw_raw[17] = 1'b1;
    step(20);
    check("b17_high", bus.sw_out[17], 1'b1);
    chg = 0;
    for (int j = 0; j < 4; j++) begin
      bus.sw_raw[17] = j[0];
      for (int c = 0; c < 7; c++) begin
        step(1);
        if (bus.sw_out[17] !== 1'b1) chg++;
      end
    end
    check("b17_no_change", chg, 0);
    bus.sw_raw[17] = 1'b0;
    wait_bit(17, 1'b0, n);
    check_range("b17_fall_lat", n, 11, 14);
`ifdef SW_DEBOUNCE_PULSE_EN
    check("b17_fall_pulse", bus.fall_pulse[17], 1'b1);
`endif
    step(1);

    // All lines at once
    bus.sw_raw = '0;
    step(20);
    bus.sw_raw = '1;
    n     = 0;
    split = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.sw_out === '1) begin
        n = c - 1;
        break;
      end
      if (bus.sw_out !== '0) split++;
    end
    check("all_same_cycle", split, 0);
    check_range("all_lat", n, 11, 14);
    step(1);

    // Reset in the middle of a count on bit 3
    bus.sw_raw = '0;
    step(20);
    bus.sw_raw[0] = 1'b1;
    step(20);
    check("pre_rst_b0", bus.sw_out[0], 1'b1);
    bus.sw_raw[3] = 1'b1;
    step(8);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", bus.sw_out, '0);
    check("rst_async_cnt", dut.g_bit[3].u_bit.cnt_q, '0);
    check("rst_async_tick", bus.tick, 1'b0);
    step(2);
    reset_n = 1'b1;
    wait_bit(3, 1'b1, n);
    check_range("rst_relat3", n, 11, 14);
    step(1);

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      bus.sw_raw = vecs[v].raw;
      step(vecs[v].hold);
      check($sformatf("vec%0d", v), bus.sw_out, vecs[v].exp);
    end

    // Random bouncing against the model
    for (int c = 0; c < 3000; c++) begin
      step(1);
      if ($urandom_range(0, 7) == 0)
        bus.sw_raw = bus.sw_raw ^ (W'($urandom) & W'($urandom));
    end
    step(20);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 18: number of switch/key lines; matches the PIO input port width.
REQ-002 Parameter CLK_DIV, default 50000: clk cycles per sample tick (1 kHz at 50 MHz); legal range >= 2.
REQ-003 Parameter STABLE_TICKS, default 10: consecutive ticks a new level must persist before it is accepted; legal range >= 1.
REQ-004 Parameter RESET_VAL, default all-zeros, WIDTH bits: value of sw_out during and after reset.
REQ-005 clk  input  1  system clock.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 sw_raw  input  WIDTH  raw asynchronous switch/key pins.
REQ-008 sw_out  output  WIDTH  debounced, registered levels; drives the PIO in_port.
REQ-009 tick  output  1  one-cycle sample strobe, exported for test and for reuse.
REQ-010 rise_pulse, fall_pulse  output  WIDTH each  present only with SW_DEBOUNCE_PULSE_EN (see Configuration).

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-012 A shared prescaler SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high for exactly the cycle in which the count equals CLK_DIV-1.
REQ-013 Each bit SHALL own a counter of clog2(STABLE_TICKS+1) bits.
REQ-014 Counter behaviour: sync==sw_out -> cleared that cycle; sync!=sw_out with tick -> incremented; otherwise held.
REQ-015 When sync!=sw_out, tick=1 and the counter equals STABLE_TICKS-1, sw_out SHALL take sync on the next edge and the counter SHALL clear.
REQ-016 A glitch shorter than one tick period that returns before the next tick SHALL clear the counter and SHALL NOT change sw_out.
REQ-017 Latency from the first sync change to the sw_out change SHALL be between (STABLE_TICKS-1)*CLK_DIV+1 and STABLE_TICKS*CLK_DIV cycles, plus 2 synchronizer cycles.
REQ-018 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each debounce on their own counters.
REQ-019 The counter SHALL never exceed STABLE_TICKS-1, so it cannot wrap.

Reset
REQ-020 Asserting reset_n low SHALL immediately set sw_out=RESET_VAL, the synchronizer flops to RESET_VAL, and the prescaler, all counters, tick and pulses to 0.
REQ-021 A reset asserted mid-debounce SHALL discard the partial count; after release, debouncing restarts from count 0.

Configuration
REQ-022 Macro SW_DEBOUNCE_PULSE_EN defined: the rise_pulse and fall_pulse ports exist.
REQ-023 With SW_DEBOUNCE_PULSE_EN, rise_pulse[i] and fall_pulse[i] SHALL be registered and high for exactly the one cycle in which sw_out[i] shows its new 1 or 0 value respectively.
REQ-024 Macro not defined: the pulse ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package sw_debounce_pkg SHALL hold the default constants (SW_WIDTH=18, SW_CLK_DIV=50000, SW_STABLE_TICKS=10) and a function computing the counter width.
REQ-026 Sub-module sw_debounce_bit SHALL hold one bit's synchronizer, counter and output flop; the top SHALL contain the prescaler and a generate loop of WIDTH instances.

Verification (CLK_DIV=4, STABLE_TICKS=3, WIDTH=18, RESET_VAL=0)
REQ-027 Reset release with sw_raw=0 -> sw_out=0; tick first high on cycle 4 after release, then every 4 cycles.
REQ-028 sw_raw[0] 0->1 held -> sw_out[0]=1 within 11..14 cycles; with the macro, rise_pulse[0] high for 1 cycle on that same cycle.
REQ-029 sw_raw[5] high for 3 cycles between ticks, then low -> sw_out[5] stays 0 and its counter returns to 0.
REQ-030 sw_raw[17] toggled every 7 cycles (bounce), then held 0 -> sw_out[17] changes once only, 11..14 cycles after the final hold begins, with a matching fall_pulse.
REQ-031 sw_raw=18'h3FFFF applied at once -> all 18 sw_out bits rise on the same cycle.
REQ-032 reset_n pulsed low while bit 3 is mid-count -> sw_out[3]=0 immediately; a full 11..14-cycle latency applies again after release.
